// File: rtl/mod_product_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_product_engine_if
// Brief    : Request/response bundle for the iterative modular multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mod_product_engine_if #(
    parameter int WIDTH = 256
);
    logic             i_valid;
    logic             o_ready;
    logic             i_mode;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_n;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_err;
    logic             o_busy;

    modport master (
        output i_valid, i_mode, i_a, i_b, i_n, i_ready,
        input  o_ready, o_valid, o_result, o_err, o_busy
    );

    modport slave (
        input  i_valid, i_mode, i_a, i_b, i_n, i_ready,
        output o_ready, o_valid, o_result, o_err, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/mod_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : mod_product_engine
// Brief    : Shift-add modular multiplier, 1 bit/cycle. Mode 0: a*b mod n,
//            mode 1: a*2^WIDTH mod n. Option macro: MODPROD_EARLY_EXIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mod_product_engine #(
    parameter int WIDTH = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mod_product_engine_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic               mode_q,   mode_d;
    logic [WIDTH-1:0]   m_q,      m_d;
    logic [WIDTH-1:0]   t_q,      t_d;
    logic [WIDTH-1:0]   areg_q,   areg_d;
    logic [WIDTH-1:0]   n_q,      n_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q,    err_d;

    logic               w_accept;
    logic               w_req_err;
    logic [WIDTH:0]     w_n_ext;
    logic [WIDTH:0]     w_mt;
    logic [WIDTH:0]     w_t2;
    logic [WIDTH:0]     w_m2;
    logic [WIDTH-1:0]   w_mt_red;
    logic [WIDTH-1:0]   w_t2_red;
    logic [WIDTH-1:0]   w_m2_red;
    logic [WIDTH-1:0]   w_m_iter;
    logic               w_last;

    assign w_accept  = bus.i_valid && (state_q == S_IDLE);
    assign w_req_err = (bus.i_n == '0) ||
                       (bus.i_mode ? (bus.i_a >= bus.i_n) : (bus.i_b >= bus.i_n));

    // m and t stay below n, so a single conditional subtract keeps them reduced.
    assign w_n_ext  = {1'b0, n_q};
    assign w_mt     = {1'b0, m_q} + {1'b0, t_q};
    assign w_t2     = {t_q, 1'b0};
    assign w_m2     = {m_q, 1'b0};
    assign w_mt_red = WIDTH'((w_mt >= w_n_ext) ? (w_mt - w_n_ext) : w_mt);
    assign w_t2_red = WIDTH'((w_t2 >= w_n_ext) ? (w_t2 - w_n_ext) : w_t2);
    assign w_m2_red = WIDTH'((w_m2 >= w_n_ext) ? (w_m2 - w_n_ext) : w_m2);

    assign w_m_iter = mode_q    ? w_m2_red :
                      areg_q[0] ? w_mt_red : m_q;

`ifdef MODPROD_EARLY_EXIT_EN
    // Stop once no multiplier bits remain above the one consumed this cycle.
    assign w_last = (cnt_q == CNT_W'(WIDTH - 1)) ||
                    (!mode_q && (areg_q[WIDTH-1:1] == '0));
`else
    assign w_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            m_q      <= '0;
            t_q      <= '0;
            areg_q   <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            m_q      <= m_d;
            t_q      <= t_d;
            areg_q   <= areg_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        m_d      = m_q;
        t_d      = t_q;
        areg_d   = areg_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    mode_d   = bus.i_mode;
                    n_d      = bus.i_n;
                    cnt_d    = '0;
                    result_d = '0;
                    m_d      = bus.i_mode ? bus.i_a : '0;
                    t_d      = bus.i_b;
                    areg_d   = bus.i_a;
                    if (w_req_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                m_d    = w_m_iter;
                t_d    = w_t2_red;
                areg_d = areg_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (w_last) begin
                    result_d = w_m_iter;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_ready  = (state_q == S_IDLE);
    assign bus.o_busy   = (state_q == S_RUN);
    assign bus.o_valid  = (state_q == S_DONE);
    assign bus.o_result = result_q;
    assign bus.o_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_product_engine
// Brief    : Self-checking bench, WIDTH=8 directed/random plus WIDTH=256 random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_product_engine;

    localparam int W8   = 8;
    localparam int W256 = 256;

    logic i_clk = 1'b0;
    logic i_rst;
    int   total = 0;
    int   bad   = 0;

    always #5 i_clk = ~i_clk;

    mod_product_engine_if #(.WIDTH(W8))   bus8 ();
    mod_product_engine_if #(.WIDTH(W256)) bus256 ();

    mod_product_engine #(.WIDTH(W8)) dut8 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus8)
    );

    mod_product_engine #(.WIDTH(W256)) dut256 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus256)
    );

    // Reference: cycles from the accept edge until o_valid is seen.
    function automatic int exp_latency(int width, bit mode, logic [255:0] a, bit err);
        int msb;
        if (err) return 1;
`ifdef MODPROD_EARLY_EXIT_EN
        if (!mode) begin
            msb = 0;
            for (int i = 0; i < width; i++) if (a[i]) msb = i;
            return msb + 2;
        end
`endif
        msb = 0;
        return width + 1;
    endfunction

    function automatic bit model8_err(bit mode, int a, int b, int n);
        return (n == 0) || (mode ? (a >= n) : (b >= n));
    endfunction

    function automatic int model8_res(bit mode, int a, int b, int n);
        if (model8_err(mode, a, b, n)) return 0;
        return mode ? ((a * 256) % n) : ((a * b) % n);
    endfunction

    task automatic scramble8();
        bus8.i_mode = 1'($urandom);
        bus8.i_a    = 8'($urandom);
        bus8.i_b    = 8'($urandom);
        bus8.i_n    = 8'($urandom);
    endtask

    task automatic run8(input bit mode, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] n, output logic [7:0] res, output logic err,
                        output int lat);
        @(negedge i_clk);
        bus8.i_valid = 1'b1;
        bus8.i_mode  = mode;
        bus8.i_a     = a;
        bus8.i_b     = b;
        bus8.i_n     = n;
        @(posedge i_clk);
        #1;
        bus8.i_valid = 1'b0;
        scramble8();
        lat = 1;
        @(negedge i_clk);
        while (bus8.o_valid !== 1'b1 && lat < W8 + 10) begin
            scramble8();
            @(negedge i_clk);
            lat++;
        end
        res = bus8.o_result;
        err = bus8.o_err;
    endtask

    task automatic release8(input int hold);
        repeat (hold) @(negedge i_clk);
        @(negedge i_clk);
        bus8.i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        bus8.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst          = 1'b1;
        bus8.i_valid   = 1'b0;
        bus8.i_ready   = 1'b0;
        scramble8();
        bus256.i_valid = 1'b0;
        bus256.i_ready = 1'b0;
        bus256.i_mode  = 1'b0;
        bus256.i_a     = '0;
        bus256.i_b     = '0;
        bus256.i_n     = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        total++; if (bus8.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus8.o_ready); end
        total++; if (bus8.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus8.o_valid); end
        total++; if (bus8.o_result !== 8'd0) begin bad++; $display("FAIL reset_result got=%0d exp=0", bus8.o_result); end
        total++; if (bus8.o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus8.o_err); end
        total++; if (bus8.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus8.o_busy); end
        total++; if (bus256.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready256 got=%b exp=1", bus256.o_ready); end
    endtask

    task automatic test_directed();
        logic [7:0] res; logic err; int lat;
        bit   m [6]   = '{0, 0, 1, 0, 0, 1};
        int   a [6]   = '{7, 255, 3, 1, 0, 10};
        int   b [6]   = '{5, 250, 0, 5, 9, 0};
        int   n [6]   = '{11, 251, 11, 11, 13, 11};
        int   exp [6] = '{2, 247, 9, 5, 0, 8};
        for (int i = 0; i < 6; i++) begin
            run8(m[i], 8'(a[i]), 8'(b[i]), 8'(n[i]), res, err, lat);
            total++; if (res !== 8'(exp[i])) begin bad++; $display("FAIL directed_result[%0d] got=%0d exp=%0d", i, res, exp[i]); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL directed_err[%0d] got=%b exp=0", i, err); end
            total++; if (lat != exp_latency(W8, m[i], 256'(a[i]), 1'b0)) begin
                bad++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, exp_latency(W8, m[i], 256'(a[i]), 1'b0));
            end
            release8(0);
        end
    endtask

    task automatic test_errors();
        logic [7:0] res; logic err; int lat;
        bit m [4] = '{0, 0, 1, 1};
        int a [4] = '{7, 3, 12, 5};
        int b [4] = '{5, 11, 0, 0};
        int n [4] = '{0, 11, 11, 0};
        for (int i = 0; i < 4; i++) begin
            run8(m[i], 8'(a[i]), 8'(b[i]), 8'(n[i]), res, err, lat);
            total++; if (err !== 1'b1) begin bad++; $display("FAIL error_flag[%0d] got=%b exp=1", i, err); end
            total++; if (res !== 8'd0) begin bad++; $display("FAIL error_result[%0d] got=%0d exp=0", i, res); end
            total++; if (lat != 1) begin bad++; $display("FAIL error_latency[%0d] got=%0d exp=1", i, lat); end
            release8(0);
        end
        run8(1'b0, 8'd4, 8'd6, 8'd7, res, err, lat);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL error_cleared got=%b exp=0", err); end
        total++; if (res !== 8'd3) begin bad++; $display("FAIL error_cleared_result got=%0d exp=3", res); end
        release8(0);
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge i_clk);
        bus8.i_valid = 1'b1;
        bus8.i_mode  = 1'b0;
        bus8.i_a     = 8'd7;
        bus8.i_b     = 8'd5;
        bus8.i_n     = 8'd11;
        @(posedge i_clk);
        #1;
        bus8.i_n = 8'd13;
        @(negedge i_clk);
        total++; if (bus8.o_busy !== 1'b1) begin bad++; $display("FAIL busy_high got=%b exp=1", bus8.o_busy); end
        total++; if (bus8.o_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", bus8.o_ready); end
        lat = 1;
        while (bus8.o_valid !== 1'b1 && lat < W8 + 10) begin
            bus8.i_a = 8'($urandom);
            @(negedge i_clk);
            lat++;
        end
        bus8.i_valid = 1'b0;
        total++; if (bus8.o_result !== 8'd2) begin bad++; $display("FAIL busy_result got=%0d exp=2", bus8.o_result); end
        total++; if (bus8.o_busy !== 1'b0) begin bad++; $display("FAIL busy_done got=%b exp=0", bus8.o_busy); end
        release8(0);
    endtask

    task automatic test_backpressure();
        logic [7:0] res; logic err; int lat;
        run8(1'b0, 8'd7, 8'd5, 8'd11, res, err, lat);
        for (int i = 0; i < 5; i++) begin
            bus8.i_valid = 1'b1;
            bus8.i_mode  = 1'b0;
            bus8.i_a     = 8'($urandom);
            bus8.i_b     = 8'd1;
            bus8.i_n     = 8'd200;
            @(negedge i_clk);
            total++; if (bus8.o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, bus8.o_valid); end
            total++; if (bus8.o_result !== 8'd2) begin bad++; $display("FAIL bp_result[%0d] got=%0d exp=2", i, bus8.o_result); end
            total++; if (bus8.o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus8.o_ready); end
        end
        bus8.i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        bus8.i_ready = 1'b0;
        bus8.i_valid = 1'b0;
        total++; if (bus8.o_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", bus8.o_valid); end
        total++; if (bus8.o_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus8.o_ready); end
        @(negedge i_clk);
        total++; if (bus8.o_busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept_in_done got=%b exp=0", bus8.o_busy); end
    endtask

    task automatic test_reset_midop();
        logic [7:0] res; logic err; int lat;
        @(negedge i_clk);
        bus8.i_valid = 1'b1;
        bus8.i_mode  = 1'b0;
        bus8.i_a     = 8'd7;
        bus8.i_b     = 8'd5;
        bus8.i_n     = 8'd11;
        @(posedge i_clk);
        #1;
        bus8.i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        total++; if (bus8.o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", bus8.o_ready); end
        total++; if (bus8.o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus8.o_busy); end
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < W8 + 2; i++) begin
            @(negedge i_clk);
            total++; if (bus8.o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid[%0d] got=%b exp=0", i, bus8.o_valid); end
        end
        run8(1'b0, 8'd7, 8'd5, 8'd11, res, err, lat);
        total++; if (res !== 8'd2 || err !== 1'b0) begin bad++; $display("FAIL midrst_fresh got=%0d/%b exp=2/0", res, err); end
        release8(0);
    endtask

    task automatic test_random8();
        logic [7:0] res; logic err; int lat;
        bit mode; int a, b, n, er, el; bit ee;
        for (int i = 0; i < 300; i++) begin
            mode = 1'($urandom);
            n    = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 255));
            a    = int'($urandom_range(0, 255));
            b    = int'($urandom_range(0, 255));
            if (n != 0 && $urandom_range(0, 9) != 0) begin
                b = b % n;
                if (mode) a = a % n;
            end
            ee = model8_err(mode, a, b, n);
            er = model8_res(mode, a, b, n);
            el = exp_latency(W8, mode, 256'(a), ee);
            run8(mode, 8'(a), 8'(b), 8'(n), res, err, lat);
            total++;
            if (res !== 8'(er) || err !== ee || lat != el) begin
                bad++;
                $display("FAIL rand8[%0d] m=%0d a=%0d b=%0d n=%0d got=%0d/%b/%0d exp=%0d/%b/%0d",
                         i, mode, a, b, n, res, err, lat, er, ee, el);
            end
            release8(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_random256();
        logic [255:0] a, b, n, r, er;
        logic [511:0] prod;
        bit mode, ee, err; int lat, el;
        for (int i = 0; i < 60; i++) begin
            for (int w = 0; w < 8; w++) begin
                a[w*32 +: 32] = $urandom;
                b[w*32 +: 32] = $urandom;
                n[w*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 1) == 0) n = n >> $urandom_range(0, 200);
            if (n == '0) n = 256'd3;
            mode = 1'($urandom);
            if (i % 10 == 9) begin
                b = n;
                a = n;
            end else begin
                b = b % n;
                if (mode) a = a % n;
            end
            ee = (mode ? (a >= n) : (b >= n));
            if (ee) er = '0;
            else if (mode) begin
                prod = {a, 256'd0} % {256'd0, n};
                er   = prod[255:0];
            end else begin
                prod = ({256'd0, a} * {256'd0, b}) % {256'd0, n};
                er   = prod[255:0];
            end
            el = exp_latency(W256, mode, a, ee);
            @(negedge i_clk);
            bus256.i_valid = 1'b1;
            bus256.i_mode  = mode;
            bus256.i_a     = a;
            bus256.i_b     = b;
            bus256.i_n     = n;
            @(posedge i_clk);
            #1;
            bus256.i_valid = 1'b0;
            bus256.i_a     = ~a;
            bus256.i_n     = ~n;
            lat = 1;
            @(negedge i_clk);
            while (bus256.o_valid !== 1'b1 && lat < W256 + 20) begin
                @(negedge i_clk);
                lat++;
            end
            r   = bus256.o_result;
            err = bus256.o_err;
            total++;
            if (r !== er || err !== ee || lat != el) begin
                bad++;
                $display("FAIL rand256[%0d] m=%0d got=%h/%b/%0d exp=%h/%b/%0d", i, mode, r, err, lat, er, ee, el);
            end
            bus256.i_ready = 1'b1;
            @(posedge i_clk);
            #1;
            bus256.i_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_busy_ignore();
        test_backpressure();
        test_reset_midop();
        test_random8();
        test_random256();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
